sync_fifo_thresh: RTL and testbench

- Single-clock, parametrised FIFO; the next generation of the team's FIFO block.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a registered read-valid strobe.
- Sits between a producer and a consumer on the same clock domain. It is the building block for the datapath buffers that do not need clock-domain crossing.

---
 rtl/sync_fifo_thresh.sv | 160 ++++++++++++++++
 tb/tb_sync_fifo_thresh.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is 1-cycle read latency.
module sync_fifo_thresh #(
   parameter int DATASIZE      = 8,
   parameter int ADDRSIZE      = 4,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_wr_en,
   input  logic [DATASIZE-1:0] i_wr_data,
   input  logic                i_rd_en,
   input  logic                i_clr_err,
   output logic [DATASIZE-1:0] o_rd_data,
   output logic                o_rd_valid,
   output logic                o_full,
   output logic                o_empty,
   output logic                o_almost_full,
   output logic                o_almost_empty,
   output logic [ADDRSIZE:0]   o_count,
   output logic                o_overflow,
   output logic                o_underflow
);

   localparam int MEM_DEPTH = 2**ADDRSIZE;
   localparam logic [ADDRSIZE:0] C_DEPTH  = (ADDRSIZE+1)'(MEM_DEPTH);
   localparam logic [ADDRSIZE:0] C_AFULL  = (ADDRSIZE+1)'(AFULL_THRESH);
   localparam logic [ADDRSIZE:0] C_AEMPTY = (ADDRSIZE+1)'(AEMPTY_THRESH);

   logic [DATASIZE-1:0] r_mem [MEM_DEPTH];
   logic [ADDRSIZE:0]   r_wr_ptr;
   logic [ADDRSIZE:0]   r_rd_ptr;
   logic [ADDRSIZE:0]   r_count;
   logic                r_full;
   logic                r_empty;
   logic                r_afull;
   logic                r_aempty;
   logic                r_ovf;
   logic                r_unf;
   logic [DATASIZE-1:0] r_rd_data;

   logic                w_wr_acc;
   logic                w_rd_acc;
   logic                w_mem_we;
   logic                w_mem_re;
   logic [ADDRSIZE:0]   w_count_nxt;

   // Acceptance depends only on registered flags, never on the opposite request.
   assign w_wr_acc    = i_wr_en & ~r_full;
   assign w_rd_acc    = i_rd_en & ~r_empty;
   assign w_count_nxt = r_count + (ADDRSIZE+1)'(w_wr_acc) - (ADDRSIZE+1)'(w_rd_acc);

`ifdef SYNC_FIFO_FWFT_EN
   logic [ADDRSIZE:0] w_mem_cnt;
   logic              w_mem_empty;
   logic              w_out_free;
   logic              w_load_wr;

   // The output register is occupied exactly when the FIFO is non-empty, so the
   // memory only holds words behind the head.
   assign w_mem_cnt   = r_wr_ptr - r_rd_ptr;
   assign w_mem_empty = (w_mem_cnt == '0);
   assign w_out_free  = r_empty | w_rd_acc;
   assign w_mem_re    = w_out_free & ~w_mem_empty;
   assign w_load_wr   = w_out_free & w_mem_empty & w_wr_acc;
   assign w_mem_we    = w_wr_acc & ~w_load_wr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_data <= '0;
      end else if (w_mem_re) begin
         r_rd_data <= r_mem[r_rd_ptr[ADDRSIZE-1:0]];
      end else if (w_load_wr) begin
         r_rd_data <= i_wr_data;
      end
   end

   assign o_rd_valid = ~r_empty;
`else
   logic r_rd_valid;

   assign w_mem_re = w_rd_acc;
   assign w_mem_we = w_wr_acc;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_rd_data <= r_mem[r_rd_ptr[ADDRSIZE-1:0]];
         end
      end
   end

   assign o_rd_valid = r_rd_valid;
`endif

   always_ff @(posedge i_clk) begin
      if (w_mem_we) begin
         r_mem[r_wr_ptr[ADDRSIZE-1:0]] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_afull  <= 1'b0;
         r_aempty <= 1'b1;
      end else begin
         if (w_mem_we) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_mem_re) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         // Flags come from the next count so they line up with o_count.
         r_count  <= w_count_nxt;
         r_full   <= (w_count_nxt == C_DEPTH);
         r_empty  <= (w_count_nxt == '0);
         r_afull  <= (w_count_nxt >= C_AFULL);
         r_aempty <= (w_count_nxt <= C_AEMPTY);
      end
   end

   // A new error event takes priority over a clear in the same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (i_wr_en & r_full) begin
            r_ovf <= 1'b1;
         end else if (i_clr_err) begin
            r_ovf <= 1'b0;
         end
         if (i_rd_en & r_empty) begin
            r_unf <= 1'b1;
         end else if (i_clr_err) begin
            r_unf <= 1'b0;
         end
      end
   end

   assign o_rd_data      = r_rd_data;
   assign o_full         = r_full;
   assign o_empty        = r_empty;
   assign o_almost_full  = r_afull;
   assign o_almost_empty = r_aempty;
   assign o_count        = r_count;
   assign o_overflow     = r_ovf;
   assign o_underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Self-checking bench for sync_fifo_thresh: queue model of contents plus a scoreboard of
// expected read data, checked after every clock edge.
module tb_sync_fifo_thresh;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int AFT   = 12;
   localparam int AET   = 2;

   logic          i_clk;
   logic          i_rst_n;
   logic          i_wr_en;
   logic [DW-1:0] i_wr_data;
   logic          i_rd_en;
   logic          i_clr_err;
   logic [DW-1:0] o_rd_data;
   logic          o_rd_valid;
   logic          o_full;
   logic          o_empty;
   logic          o_almost_full;
   logic          o_almost_empty;
   logic [AW:0]   o_count;
   logic          o_overflow;
   logic          o_underflow;

   int            n_tests;
   int            n_fail;
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] sb_q[$];
   int            m_count;
   logic          m_ovf;
   logic          m_unf;

   sync_fifo_thresh #(
      .DATASIZE(DW), .ADDRSIZE(AW), .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
      .i_rd_en(i_rd_en), .i_clr_err(i_clr_err), .o_rd_data(o_rd_data),
      .o_rd_valid(o_rd_valid), .o_full(o_full), .o_empty(o_empty),
      .o_almost_full(o_almost_full), .o_almost_empty(o_almost_empty),
      .o_count(o_count), .o_overflow(o_overflow), .o_underflow(o_underflow)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_status();
      chk("count", 32'(o_count), 32'(m_count));
      chk("full", 32'(o_full), 32'(m_count == DEPTH));
      chk("empty", 32'(o_empty), 32'(m_count == 0));
      chk("almost_full", 32'(o_almost_full), 32'(m_count >= AFT));
      chk("almost_empty", 32'(o_almost_empty), 32'(m_count <= AET));
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
      chk("underflow", 32'(o_underflow), 32'(m_unf));
   endtask

   // One clock cycle of stimulus; called at posedge+1.
   task automatic cyc(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
      logic          wa;
      logic          ra;
      logic [DW-1:0] e;
      i_wr_en   = wr;
      i_wr_data = d;
      i_rd_en   = rd;
      i_clr_err = clr;
      wa = wr && (m_count != DEPTH);
      ra = rd && (m_count != 0);
`ifdef SYNC_FIFO_FWFT_EN
      if (m_count != 0) chk("fwft_head", 32'(o_rd_data), 32'(m_q[0]));
`endif
      if (ra) begin
         e = m_q.pop_front();
         sb_q.push_back(e);
      end
      if (wa) m_q.push_back(d);
      m_count = m_q.size();
      if (wr && !wa) m_ovf = 1'b1;
      else if (clr)  m_ovf = 1'b0;
      if (rd && !ra) m_unf = 1'b1;
      else if (clr)  m_unf = 1'b0;
      @(posedge i_clk);
      #1;
      chk_status();
`ifdef SYNC_FIFO_FWFT_EN
      chk("rd_valid", 32'(o_rd_valid), 32'(m_count != 0));
      if (ra) void'(sb_q.pop_front());
`else
      chk("rd_valid", 32'(o_rd_valid), 32'(ra));
      if (ra) chk("rd_data", 32'(o_rd_data), 32'(sb_q.pop_front()));
`endif
      i_wr_en   = 1'b0;
      i_rd_en   = 1'b0;
      i_clr_err = 1'b0;
   endtask

   task automatic do_reset();
      i_rst_n   = 1'b0;
      i_wr_en   = 1'b0;
      i_rd_en   = 1'b0;
      i_clr_err = 1'b0;
      i_wr_data = '0;
      m_q.delete();
      sb_q.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      #1;
      chk_status();
      chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
      chk("rst_rd_data", 32'(o_rd_data), 32'd0);
      @(posedge i_clk);
      #1;
      chk_status();
      i_rst_n = 1'b1;
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      i_rst_n   = 1'b1;
      i_wr_en   = 1'b0;
      i_rd_en   = 1'b0;
      i_clr_err = 1'b0;
      i_wr_data = '0;
      m_count   = 0;
      m_ovf     = 1'b0;
      m_unf     = 1'b0;
      #1;
      do_reset();

      // Fill, overflow attempt, then drain in order.
      for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
      cyc(1'b1, 8'hAA, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);

      // Underflow, clear, and set-beats-clear.
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b1, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);

      // Steady state at 8 entries with pointers wrapping.
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) cyc(1'b1, 8'(8'h28 + i), 1'b1, 1'b0);

      // Full with both requests: read wins, write dropped.
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      cyc(1'b1, 8'hEE, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

      // Reset mid-stream with 5 entries stored.
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
      do_reset();
      cyc(1'b1, 8'h5C, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
      chk("fwft_5c", 32'(o_rd_data), 32'h5C);
`endif
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
